// File: rtl/fetch_queue.sv
// Instruction prefetch queue between fetch and decode.
// Buffers imem words together with their PC+4 so decode stalls and imem wait states
// are decoupled. Entries leave strictly in order; a flush discards everything fetched.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   ihit_i       imem presents a valid word this cycle
//   imemload_i   instruction word from imem
//   fnpc_i       PC+4 of the word on imemload_i
//   deq_i        decode consumes the head entry
//   flush_i      discard all entries (taken branch/jump)
//   push_ack_o   word accepted this cycle; fetch advances PC on this
//   instr_o      head instruction, 0 when empty
//   npc_o        head PC+4, 0 when empty
//   valid_o      queue non-empty
//   full_o       queue holds Depth entries
//   count_o      number of occupied entries
module fetch_queue #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Cw    = $clog2(Depth) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          ihit_i,
  input  logic [31:0]   imemload_i,
  input  logic [31:0]   fnpc_i,
  input  logic          deq_i,
  input  logic          flush_i,
  output logic          push_ack_o,
  output logic [31:0]   instr_o,
  output logic [31:0]   npc_o,
  output logic          valid_o,
  output logic          full_o,
  output logic [Cw-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] npc;
  } entry_t;

  entry_t          mem_q [Depth];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [Cw-1:0]   count_q, count_d;
  logic            pop;
  logic            push;

  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == Cw'(Depth));
  assign count_o = count_q;

  assign pop  = deq_i & valid_o & ~flush_i;
  // Gated by reset so fetch never advances while the queue is held in reset.
  assign push = ihit_i & (~full_o | pop) & ~flush_i & rst_ni;
  assign push_ack_o = push;

  assign instr_o = valid_o ? mem_q[rd_ptr_q].instr : 32'h0;
  assign npc_o   = valid_o ? mem_q[rd_ptr_q].npc   : 32'h0;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + Cw'(1);
        2'b01:   count_d = count_q - Cw'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= '{instr: imemload_i, npc: fnpc_i};
  end

  count_in_range_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_q <= Cw'(Depth));
  no_underflow_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pop && count_q == '0));
  no_overflow_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && !pop && count_q == Cw'(Depth)));

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int unsigned Depth = 4;
  localparam int unsigned Cw    = 3;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          ihit_i;
  logic [31:0]   imemload_i;
  logic [31:0]   fnpc_i;
  logic          deq_i;
  logic          flush_i;
  logic          push_ack_o;
  logic [31:0]   instr_o;
  logic [31:0]   npc_o;
  logic          valid_o;
  logic          full_o;
  logic [Cw-1:0] count_o;

  fetch_queue #(.Depth(Depth), .Cw(Cw)) u_dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .ihit_i     (ihit_i),
    .imemload_i (imemload_i),
    .fnpc_i     (fnpc_i),
    .deq_i      (deq_i),
    .flush_i    (flush_i),
    .push_ack_o (push_ack_o),
    .instr_o    (instr_o),
    .npc_o      (npc_o),
    .valid_o    (valid_o),
    .full_o     (full_o),
    .count_o    (count_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference: a plain FIFO of {instr, npc} pairs.
  logic [63:0] model_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    ihit_i = 1'b1;
    deq_i  = 1'b0;
    flush_i = 1'b0;
    imemload_i = 32'hdead_beef;
    fnpc_i = 32'h4;
    @(negedge clk_i);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_npc", npc_o, 32'h0);
    check("rst_full", 32'(full_o), 32'd0);
    check("rst_ack", 32'(push_ack_o), 32'd0);
    @(posedge clk_i);
    #1;
    model_q.delete();
    rst_ni = 1'b1;
    ihit_i = 1'b0;
  endtask

  // One clock: drive, check combinational outputs against the model, then advance model.
  task automatic step(input logic ih, input logic [31:0] w, input logic [31:0] pc,
                      input logic dq, input logic fl);
    int  sz;
    logic exp_pop, exp_ack;
    logic [31:0] exp_instr, exp_npc;
    ihit_i = ih; imemload_i = w; fnpc_i = pc; deq_i = dq; flush_i = fl;
    @(negedge clk_i);
    sz = model_q.size();
    exp_pop = dq && sz != 0 && !fl;
    exp_ack = ih && (sz < Depth || exp_pop) && !fl;
    exp_instr = (sz != 0) ? model_q[0][63:32] : 32'h0;
    exp_npc   = (sz != 0) ? model_q[0][31:0]  : 32'h0;
    check("push_ack", 32'(push_ack_o), 32'(exp_ack));
    check("valid", 32'(valid_o), 32'(sz != 0));
    check("full", 32'(full_o), 32'(sz == Depth));
    check("count", 32'(count_o), 32'(sz));
    check("instr", instr_o, exp_instr);
    check("npc", npc_o, exp_npc);
    @(posedge clk_i);
    if (fl) model_q.delete();
    else begin
      if (exp_pop) void'(model_q.pop_front());
      if (exp_ack) model_q.push_back({w, pc});
    end
    #1;
  endtask

  initial begin
    rst_ni = 1'b0; ihit_i = 1'b0; deq_i = 1'b0; flush_i = 1'b0;
    imemload_i = '0; fnpc_i = '0;
    repeat (2) @(posedge clk_i);
    #1;

    // Reset held with ihit, then first push accepted.
    do_reset();
    step(1'b1, 32'h10, 32'h1004, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Fill, blocked fifth push, full push+pop, drain.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h11 + i, 32'h2004 + 4 * i, 1'b0, 1'b0);
    step(1'b1, 32'h15, 32'h2014, 1'b0, 1'b0);
    check("full_head", instr_o, 32'h11);
    step(1'b1, 32'h15, 32'h2014, 1'b1, 1'b0);
    check("full_pp_count", 32'(count_o), 32'd4);
    check("full_pp_head", instr_o, 32'h12);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("drained", 32'(valid_o), 32'd0);

    // Flush has priority over same-cycle push and pop.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h21 + i, 32'h3004 + 4 * i, 1'b0, 1'b0);
    step(1'b1, 32'h99, 32'h9999, 1'b1, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Pointer wrap with steady occupancy of one.
    step(1'b1, 32'h30, 32'h4000, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) step(1'b1, 32'h30 + i, 32'h4000 + 4 * i, 1'b1, 1'b0);
    check("wrap_count", 32'(count_o), 32'd1);
    check("wrap_head", instr_o, 32'h3a);

    // Dequeue while empty is ignored; next push appears a cycle later.
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h55, 32'h5004, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("empty_deq_npc", npc_o, 32'h5004);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else step($urandom_range(0, 3) != 0, $urandom, $urandom,
                $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
